// File: rtl/serial_pkg.sv
// Shared definitions for the serial TX/RX path: state encoding, default line rate,
// bit-time helpers and frame-length constants.
package serial_pkg;

    typedef enum logic [2:0] {
        SERIAL_IDLE   = 3'd0,
        SERIAL_START  = 3'd1,
        SERIAL_DATA   = 3'd2,
        SERIAL_PARITY = 3'd3,
        SERIAL_STOP   = 3'd4
    } serial_state_e;

    localparam int unsigned SERIAL_CLK_FREQ  = 50_000_000;
    localparam int unsigned SERIAL_BAUD_RATE = 115_200;

    // Frame lengths in bit times: start + 8 data (+ parity) + stop.
    localparam int unsigned SERIAL_FRAME_BITS_8E1 = 11;
    localparam int unsigned SERIAL_FRAME_BITS_8N1 = 10;

    function automatic int unsigned serial_bit_ticks(input int unsigned clk_freq,
                                                     input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned serial_frame_cycles(input int unsigned frame_bits,
                                                        input int unsigned bit_ticks);
        return frame_bits * bit_ticks;
    endfunction

    localparam int unsigned SERIAL_BIT_TICKS =
        serial_bit_ticks(SERIAL_CLK_FREQ, SERIAL_BAUD_RATE);

endpackage

// File: rtl/serial_tx_baud_counter.sv
// Bit-time counter: counts 0..BIT_TICKS-1 and pulses bit_end on the last count.
// Shared between the serial transmitter and receiver.
module baud_counter #(
    parameter int unsigned BIT_TICKS = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned CW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_TICKS - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bit_end = (r_count == LAST);

endmodule

// File: rtl/serial_tx.sv
// RS-232 transmitter: start, 8 data bits LSB first, optional even parity, one stop bit.
// Define SERIAL_TX_PARITY_EN for an 8E1 frame; default build sends 8N1.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = SERIAL_CLK_FREQ,
    parameter int unsigned BAUD_RATE = SERIAL_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       cts,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned BIT_TICKS = serial_bit_ticks(CLK_FREQ, BAUD_RATE);

    serial_state_e r_state;
    logic [7:0]    r_data;
    logic [2:0]    r_bit_idx;
    logic          r_tx;
    logic          r_busy;
`ifdef SERIAL_TX_PARITY_EN
    logic          r_parity;
`endif

    logic       w_bit_end;
    logic       w_accept;
    logic       w_clear;
    logic [2:0] w_next_idx;

    assign data_ready = !rst && (r_state == SERIAL_IDLE) && cts;
    assign w_accept   = data_valid && data_ready;
    assign w_next_idx = r_bit_idx + 3'd1;
    // Holding the counter clear through IDLE means it starts at 0 on the accept edge.
    assign w_clear    = (r_state == SERIAL_IDLE);

    baud_counter #(
        .BIT_TICKS (BIT_TICKS)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .bit_end (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= SERIAL_IDLE;
            r_data    <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                SERIAL_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        r_data    <= data;
`ifdef SERIAL_TX_PARITY_EN
                        r_parity  <= ^data;
`endif
                        r_bit_idx <= '0;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= SERIAL_START;
                    end
                end
                SERIAL_START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_data[0];
                        r_state <= SERIAL_DATA;
                    end
                end
                SERIAL_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= SERIAL_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= SERIAL_STOP;
`endif
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= r_data[w_next_idx];
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                SERIAL_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= SERIAL_STOP;
                    end
                end
`endif
                SERIAL_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_busy  <= 1'b0;
                        r_state <= SERIAL_IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= SERIAL_IDLE;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;

endmodule

// File: doc/serial_tx.md
# serial_tx

RS-232 transmitter for the serial echo path. It accepts one byte per valid/ready handshake and shifts it out on `tx` as a standard asynchronous frame: start bit, 8 data bits LSB first, optional even parity bit, one stop bit. Bit time is derived from the system clock (115200 baud at 50 MHz). It is the output stage opposite the receiver and feeds the board's TX pin.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s. `BIT_TICKS = CLK_FREQ / BAUD_RATE` uses integer division, giving 434 at the defaults.

- `clk`  in  1: system clock. This is the only clock.
- `rst`  in  1: synchronous reset, active-high.
- `data`  in  8: byte to send. Sampled only on the accept edge.
- `data_valid`  in  1: `data` is valid.
- `data_ready`  out  1: the block can accept a byte. Combinational: `!rst && state==IDLE && cts`.
- `cts`  in  1: clear-to-send from the peer. 1 means sending is allowed.
- `tx`  out  1: serial line, registered. Idles at 1.
- `busy`  out  1: registered. High from the accept edge until the frame ends.

## Operation
- States are IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1.
  - On an edge with `data_valid && data_ready`: latch `data`, compute parity = `^data`, go to START, set `tx`<=0 and `busy`<=1, clear the tick and bit counters.
- Every bit is held for exactly `BIT_TICKS` cycles. A tick counter of width `$clog2(BIT_TICKS)` counts 0..BIT_TICKS-1 and wraps to 0 at each bit boundary.
- START: at the bit boundary, go to DATA and set `tx`<=d[0].
- DATA:
  - A 3-bit index selects the data bit; 8 bits are sent, LSB first.
  - After d[7], go to PARITY if parity is enabled, otherwise go to STOP.
- PARITY: `tx` = stored even-parity bit, then go to STOP.
- STOP:
  - `tx`=1.
  - At the boundary, go to IDLE and set `busy`<=0.
- `cts` is checked only at accept time. Dropping `cts` mid-frame does not stop the frame; the current frame always completes.
- Changes on `data` or `data_valid` after the accept edge are ignored until the block is back in IDLE.
- Reset, including mid-frame:
  - At the next edge: state=IDLE, `tx`=1, `busy`=0, counters=0, and the frame is dropped.
  - `data_ready`=0 while `rst`=1.
- Simultaneous `rst` and a handshake: reset wins, and the byte is not accepted.

## Timing
- Reset values: `tx`=1, `busy`=0, `data_ready`=0 while `rst` is high.
- Accept edge E0. `tx` falls to 0 right after E0, so latency from handshake to start bit is 0 cycles.
- Data bit d[i] drives `tx` from E0+(1+i)·434 for 434 cycles.
- Parity bit starts at E0+9·434. Stop bit starts at E0+10·434 with parity, or E0+9·434 without.
- Frame ends at E0+4774 (parity) or E0+4340 (no parity): state=IDLE and `busy`=0.
- `data_ready` goes high in the cycle after the frame ends. The earliest next accept is at E0+4775, so the effective stop bit is 435 cycles.
- Throughput: one byte every 4775 cycles, about 10471 bytes/s at 50 MHz with parity.

## Configuration
- Macro `SERIAL_TX_PARITY_EN`.
- Defined: 8E1 frame. The PARITY state is present, frame is 11 bits / 4774 cycles.
- Undefined: 8N1 frame. The PARITY state and parity register are removed, DATA goes straight to STOP, frame is 10 bits / 4340 cycles.

## Structure
- Shared package `serial_pkg` holds:
  - the state encoding (`SERIAL_IDLE`..`SERIAL_STOP`, 3 bits);
  - default `CLK_FREQ`/`BAUD_RATE`;
  - the `BIT_TICKS` constant/function;
  - the frame-length constants.
- The receiver uses the same package.
- Sub-module `baud_counter`:
  - parameterised by `BIT_TICKS`;
  - inputs: `clk`, `rst`, `clear`;
  - output: `bit_end`, a one-cycle pulse when the count reaches BIT_TICKS-1.
- The receiver reuses `baud_counter`.

## Test plan
- Reset, then release with `cts`=1: `tx`=1, `busy`=0, `data_ready`=1 in the first cycle after release. While `rst`=1, `data_ready`=0.
- Send 0x53 (parity on) → `tx`, sampled mid-bit every 434 cycles, reads 0,1,1,0,0,1,0,1,0,0,1 (start, 8 data bits LSB first, parity 0, stop). `busy` is high for 4774 cycles.
- Send 0x54 (the echoed 0x53+1) → data bits 0,0,1,0,1,0,1,0 and parity 1. Rebuild with the macro undefined: the same data bits with no parity bit, and `busy` high for 4340 cycles.
- Hold `data_valid`=1, `data`=0xA5 with `cts`=0 for 1000 cycles → `tx` stays 1 and `data_ready`=0. Raise `cts` → accept on the next edge. Drop `cts` mid-frame → the frame still completes.
- Back-to-back 0x00 then 0xFF with `data_valid` held → the second start bit begins exactly 4775 cycles after the first accept. Both parity bits are 0.
- Assert `rst` for 1 cycle during data bit d[3] of 0x5A → `tx`=1 and `busy`=0 at the next edge. A following 0x3C frame is bit-exact.
